// File: rtl/input_debouncer.sv
// ============================================================================
// Module   : input_debouncer
// Purpose  : Synchronizes a raw asynchronous level (switch/button) into the
//            clk domain and accepts a new level only after it has been seen on
//            STABLE_CYCLES consecutive rising edges. Emits one-cycle rise/fall
//            pulses when the debounced level changes.
// Ports    : clk  - single clock, all state updates on the rising edge
//            clrn - asynchronous, active-low reset
//            d_in - raw asynchronous input level
//            q    - debounced, synchronized level (registered)
//            rise - one-cycle registered pulse on q 0->1
//            fall - one-cycle registered pulse on q 1->0
//            busy - high while a candidate level change is being qualified
// Config   : `define INPUT_DEBOUNCER_SYNC3_EN selects a 3-stage synchronizer
//            (adds one cycle of latency); undefined selects 2 stages.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_debouncer #(
  parameter int STABLE_CYCLES = 4,   // legal range 2..65535
  parameter int CNT_W         = 16   // must hold STABLE_CYCLES-1
) (
  input  logic clk,
  input  logic clrn,
  input  logic d_in,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

`ifdef INPUT_DEBOUNCER_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  // --------------------------------------------------------------------------
  // Synchronizer chain; s is the only signal the FSM ever looks at.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Qualification FSM. cnt counts edges at which s has held the candidate
  // level; entering a WAIT state already counts the first such edge, so the
  // change is accepted on the STABLE_CYCLES-th consecutive edge.
  // --------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
        end else if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d = IDLE_HIGH;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
        end else if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d = IDLE_LOW;
        end
      end
      default: begin
        state_d = IDLE_LOW;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. q is a dedicated flop (decoded from the next state) so that
  // downstream logic sees a clean register output rather than a state decode.
  // Pulses compare the next level against the current one, so they assert on
  // the same edge at which q changes and last exactly one cycle.
  // --------------------------------------------------------------------------
  logic q_q, q_d;
  logic rise_q, fall_q;

  assign q_d = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rise_q <= q_d & ~q_q;
      fall_q <= ~q_d & q_q;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule

`default_nettype wire

// File: tb/tb_input_debouncer.sv
// ============================================================================
// Module   : tb_input_debouncer
// Purpose  : Directed self-checking bench for input_debouncer with
//            STABLE_CYCLES=4. Honors INPUT_DEBOUNCER_SYNC3_EN for latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_debouncer;

  localparam int STABLE = 4;
`ifdef INPUT_DEBOUNCER_SYNC3_EN
  localparam int SYNC = 3;
`else
  localparam int SYNC = 2;
`endif
  // Edge index (after E0) at which q changes: E0 + STABLE + SYNC - 1.
  localparam int QE = STABLE + SYNC - 1;

  logic clk;
  logic clrn;
  logic d_in;
  logic q;
  logic rise;
  logic fall;
  logic busy;

  int n_cmp;
  int n_err;

  int rise_cnt;
  int fall_cnt;
  int dbl_cnt;
  int both_cnt;
  logic prev_rise;
  logic prev_fall;

  int base_r;
  int base_f;

  input_debouncer #(
    .STABLE_CYCLES(STABLE),
    .CNT_W        (16)
  ) dut (
    .clk (clk),
    .clrn(clrn),
    .d_in(d_in),
    .q   (q),
    .rise(rise),
    .fall(fall),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled mid-cycle.
  initial begin
    rise_cnt  = 0;
    fall_cnt  = 0;
    dbl_cnt   = 0;
    both_cnt  = 0;
    prev_rise = 1'b0;
    prev_fall = 1'b0;
  end

  always @(negedge clk) begin
    if (rise) rise_cnt = rise_cnt + 1;
    if (fall) fall_cnt = fall_cnt + 1;
    if ((rise && prev_rise) || (fall && prev_fall)) dbl_cnt = dbl_cnt + 1;
    if (rise && fall) both_cnt = both_cnt + 1;
    prev_rise = rise;
    prev_fall = fall;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp = n_cmp + 1;
    if (obs != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    d_in  = 1'b0;
    clrn  = 1'b0;

    // Reset state
    #1;
    check_eq("reset_q",    int'(q),    0);
    check_eq("reset_rise", int'(rise), 0);
    check_eq("reset_fall", int'(fall), 0);
    check_eq("reset_busy", int'(busy), 0);
    #11 clrn = 1'b1;
    tick(); tick(); tick();

    // Rising qualification with latency and busy window
    base_r = rise_cnt;
    d_in = 1'b1;
    tick();                                  // E0
    for (int e = 1; e <= QE; e++) begin
      tick();
      check_eq($sformatf("rise_q_E%0d", e),    int'(q),    (e >= QE) ? 1 : 0);
      check_eq($sformatf("rise_rise_E%0d", e), int'(rise), (e == QE) ? 1 : 0);
      check_eq($sformatf("rise_busy_E%0d", e), int'(busy), (e >= SYNC && e < QE) ? 1 : 0);
    end
    tick();
    check_eq("rise_pulse_end", int'(rise), 0);
    check_eq("rise_q_hold",    int'(q),    1);
    check_eq("rise_count",     rise_cnt - base_r, 1);

    // Falling qualification
    base_f = fall_cnt;
    d_in = 1'b0;
    tick();                                  // E0
    for (int e = 1; e <= QE; e++) begin
      tick();
      check_eq($sformatf("fall_q_E%0d", e),    int'(q),    (e >= QE) ? 0 : 1);
      check_eq($sformatf("fall_fall_E%0d", e), int'(fall), (e == QE) ? 1 : 0);
    end
    tick();
    check_eq("fall_pulse_end", int'(fall), 0);
    check_eq("fall_count",     fall_cnt - base_f, 1);

    // Glitch of STABLE-1 samples: reverts on the final qualifying edge
    base_r = rise_cnt;
    base_f = fall_cnt;
    d_in = 1'b1;
    tick(); tick(); tick();
    d_in = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      check_eq($sformatf("glitch_q_%0d", e), int'(q), 0);
    end
    check_eq("glitch_busy",  int'(busy), 0);
    check_eq("glitch_rises", rise_cnt - base_r, 0);
    check_eq("glitch_falls", fall_cnt - base_f, 0);

    // Exactly STABLE samples high: accepted, then falls back
    base_r = rise_cnt;
    base_f = fall_cnt;
    d_in = 1'b1;
    tick(); tick(); tick(); tick();
    d_in = 1'b0;
    for (int e = 0; e < 12; e++) tick();
    check_eq("exact_rises", rise_cnt - base_r, 1);
    check_eq("exact_falls", fall_cnt - base_f, 1);
    check_eq("exact_q",     int'(q), 0);

    // Toggling every cycle
    base_r = rise_cnt;
    base_f = fall_cnt;
    for (int e = 0; e < 40; e++) begin
      d_in = ~d_in;
      tick();
      check_eq($sformatf("toggle_q_%0d", e), int'(q), 0);
    end
    d_in = 1'b0;
    for (int e = 0; e < 6; e++) tick();
    check_eq("toggle_rises", rise_cnt - base_r, 0);
    check_eq("toggle_falls", fall_cnt - base_f, 0);
    check_eq("toggle_busy",  int'(busy), 0);

    // Reset mid-qualification, then requalify the held level
    base_r = rise_cnt;
    d_in = 1'b1;
    tick();                                  // E0
    for (int e = 1; e <= SYNC; e++) tick();
    check_eq("midrst_busy_before", int'(busy), 1);
    #2 clrn = 1'b0;
    #1;
    check_eq("midrst_async_q",    int'(q),    0);
    check_eq("midrst_async_busy", int'(busy), 0);
    check_eq("midrst_async_rise", int'(rise), 0);
    #1 clrn = 1'b1;
    tick();                                  // first post-reset edge
    for (int e = 1; e <= QE; e++) begin
      tick();
      check_eq($sformatf("postrst_q_E%0d", e), int'(q), (e >= QE) ? 1 : 0);
    end
    check_eq("postrst_rise", int'(rise), 1);
    check_eq("postrst_rise_count", rise_cnt - base_r, 0);
    tick();
    check_eq("postrst_rise_count2", rise_cnt - base_r, 1);

    // Reset asserted just ahead of the qualifying edge wins
    d_in = 1'b0;
    for (int e = 0; e < 12; e++) tick();
    check_eq("prewin_q", int'(q), 0);
    base_r = rise_cnt;
    d_in = 1'b1;
    tick();                                  // E0
    for (int e = 1; e < QE; e++) tick();
    check_eq("win_q_before", int'(q), 0);
    check_eq("win_busy_before", int'(busy), 1);
    #8 clrn = 1'b0;
    @(posedge clk);
    #1;
    check_eq("win_q",    int'(q),    0);
    check_eq("win_rise", int'(rise), 0);
    d_in = 1'b0;
    clrn = 1'b1;
    for (int e = 0; e < 8; e++) tick();
    check_eq("win_rise_count", rise_cnt - base_r, 0);
    check_eq("win_q_after",    int'(q), 0);

    check_eq("double_pulses", dbl_cnt,  0);
    check_eq("both_pulses",   both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive synchronized samples required to accept a new level; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16: counter width; SHALL hold STABLE_CYCLES-1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 clrn  input  1  reset; asynchronous, active-low.
REQ-005 d_in  input  1  raw asynchronous level (switch/button), unrelated to clk.
REQ-006 q  output  1  debounced, synchronized level; feeds downstream D flip-flops directly.
REQ-007 rise  output  1  one-cycle pulse when q goes 0->1.
REQ-008 fall  output  1  one-cycle pulse when q goes 1->0.
REQ-009 busy  output  1  high while a candidate level change is being qualified.

Function
REQ-010 d_in SHALL pass through a synchronizer chain of flops, all clocked by clk and cleared by clrn; the last stage output is s.
REQ-011 FSM states SHALL be IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW; q=0 in IDLE_LOW/WAIT_HIGH, q=1 in IDLE_HIGH/WAIT_LOW.
REQ-012 IDLE_LOW: s=1 at an edge -> WAIT_HIGH, cnt=1; else stay, cnt=0.
REQ-013 WAIT_HIGH: s=1 and cnt<STABLE_CYCLES-1 -> cnt+1, stay; s=1 and cnt=STABLE_CYCLES-1 -> IDLE_HIGH, cnt=0; s=0 -> IDLE_LOW, cnt=0.
REQ-014 IDLE_HIGH/WAIT_LOW SHALL mirror REQ-012/013 with polarities swapped.
REQ-015 q SHALL change on the STABLE_CYCLES-th consecutive edge at which s holds the new value; no earlier, no later.
REQ-016 With 2-stage sync, a d_in change held stable before edge E0 SHALL update q at edge E0+STABLE_CYCLES+1.
REQ-017 rise (fall) SHALL be registered, high for exactly the one cycle following the edge where q rises (falls); never both high; never high for two consecutive cycles.
REQ-018 Glitch: any s pulse shorter than STABLE_CYCLES samples SHALL leave q, rise and fall unchanged and return the FSM to the originating IDLE state.
REQ-019 Reversion on the final qualifying edge (s returns at cnt=STABLE_CYCLES-1) SHALL abort; q unchanged.
REQ-020 busy SHALL be 1 exactly in WAIT_HIGH/WAIT_LOW.
REQ-021 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.

Reset
REQ-022 clrn=0 SHALL immediately, without a clock, force: sync flops=0, state=IDLE_LOW, cnt=0, q=0, rise=0, fall=0, busy=0.
REQ-023 Reset mid-qualification SHALL discard the pending change; no pulse emitted.
REQ-024 After clrn deasserts with d_in held 1, the block SHALL qualify it as a normal 0->1 change and pulse rise once.
REQ-025 Reset asserted on the same edge as a qualifying transition SHALL win; q stays 0.

Configuration
REQ-026 Macro INPUT_DEBOUNCER_SYNC3_EN: defined -> 3-stage synchronizer, REQ-016 latency becomes STABLE_CYCLES+2; undefined -> 2-stage synchronizer, latency STABLE_CYCLES+1. FSM behaviour otherwise identical.

Verification (STABLE_CYCLES=4, macro undefined unless noted)
REQ-027 Reset, d_in 0->1 before edge E0, held -> q=1 and rise=1 at E5, rise=0 at E6, busy high E2..E4.
REQ-028 d_in high for 3 cycles, then 0 -> q stays 0, rise/fall never asserted, busy returns 0, FSM in IDLE_LOW.
REQ-029 q=1 steady, d_in 1->0 held -> q=0 and fall=1 at E0+5; fall single-cycle.
REQ-030 d_in 0->1 held, clrn pulsed low between E2 and E3 -> q=0, busy=0 asynchronously; after release, q rises 5 edges after the first post-reset edge.
REQ-031 d_in toggling every cycle for 40 cycles -> q constant, zero pulses, cnt never above 1.
REQ-032 Macro INPUT_DEBOUNCER_SYNC3_EN defined, repeat REQ-027 -> q=1 and rise=1 at E6.
